// File: rtl/onehot_encode_seq.sv
// ============================================================================
// Module   : onehot_encode_seq
// Function : Sequential one-hot encoder. Scans a captured 2**WIDTH-bit word
//            one bit per clock, reporting index, set-bit count and error.
//            Optional macro ONEHOT_ENC_PRIORITY_EN selects highest-index mode.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module onehot_encode_seq #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2**WIDTH-1:0]   dec_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      enc_data,
    output logic [WIDTH:0]        bit_cnt,
    output logic                  err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_SCAN  = 2'd1;
    localparam logic [1:0]       c_ST_HOLD  = 2'd2;
    localparam logic [WIDTH-1:0] c_LAST_IDX = '1;
    localparam logic [WIDTH:0]   c_CNT_ONE  = (WIDTH+1)'(1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [2**WIDTH-1:0]  r_word;
    logic [WIDTH-1:0]     r_idx;
    logic [WIDTH:0]       r_cnt;
    logic [WIDTH-1:0]     r_enc;
    logic                 r_err;
    logic                 w_bit;
    logic [WIDTH:0]       w_cnt_next;
    logic                 w_err_next;
    logic                 w_take_idx;

    assign w_bit      = r_word[r_idx];
    assign w_cnt_next = r_cnt + {{WIDTH{1'b0}}, w_bit};

`ifdef ONEHOT_ENC_PRIORITY_EN
    // Later set bits overwrite, leaving the highest index; only empty is illegal.
    assign w_take_idx = w_bit;
    assign w_err_next = (w_cnt_next == '0);
`else
    // Only the first set bit seen (count still zero) is recorded.
    assign w_take_idx = w_bit && (r_cnt == '0);
    assign w_err_next = (w_cnt_next != c_CNT_ONE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (in_valid)               w_state_next = c_ST_SCAN;
            c_ST_SCAN: if (r_idx == c_LAST_IDX)    w_state_next = c_ST_HOLD;
            c_ST_HOLD: if (out_ready)              w_state_next = c_ST_IDLE;
            default:                               w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_enc  <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (in_valid) begin
                        r_word <= dec_data;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_enc  <= '0;
                        r_err  <= 1'b0;
                    end
                end
                c_ST_SCAN: begin
                    r_idx <= r_idx + 1'b1;
                    r_cnt <= w_cnt_next;
                    if (w_take_idx) begin
                        r_enc <= r_idx;
                    end
                    // Error is settled from the final count on the last scan edge.
                    if (r_idx == c_LAST_IDX) begin
                        r_err <= w_err_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = (r_state == c_ST_IDLE);
    assign out_valid = (r_state == c_ST_HOLD);
    assign enc_data  = r_enc;
    assign bit_cnt   = r_cnt;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_onehot_encode_seq.sv
// ============================================================================
// Module   : tb_onehot_encode_seq
// Function : Directed self-checking bench for onehot_encode_seq (WIDTH=4).
//            Expectations follow ONEHOT_ENC_PRIORITY_EN when it is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_onehot_encode_seq;

    localparam int c_WIDTH = 4;

    logic        clk;
    logic        rst_n;
    logic [15:0] dec_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  enc_data;
    logic [4:0]  bit_cnt;
    logic        err;
    logic        out_valid;
    logic        out_ready;

    int n_vec;
    int n_err;

    onehot_encode_seq #(.WIDTH(c_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dec_data  (dec_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .enc_data  (enc_data),
        .bit_cnt   (bit_cnt),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    // Accepts one word and checks latency and the HOLD result; if out_ready is
    // high it also checks the return to IDLE with the result retained.
    task automatic run_word(input logic [15:0] word, input logic [3:0] e_enc,
                            input logic [4:0] e_cnt, input logic e_err, input string name);
        int   waited;
        logic early;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready);
        end
        dec_data = word;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dec_data = ~word;
        early = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) early = 1'b1;
            @(posedge clk); #1;
        end
        if (out_valid !== 1'b0) early = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (early !== 1'b0 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s latency: early=%b out_valid@16=%b want early=0 out_valid=1",
                     name, early, out_valid);
        end
        n_vec++;
        if (enc_data !== e_enc || bit_cnt !== e_cnt || err !== e_err) begin
            n_err++;
            $display("FAIL %s result: got enc=%0d cnt=%0d err=%b want enc=%0d cnt=%0d err=%b",
                     name, enc_data, bit_cnt, err, e_enc, e_cnt, e_err);
        end
        if (out_ready === 1'b1) begin
            @(posedge clk); #1;
            n_vec++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_data !== e_enc ||
                bit_cnt !== e_cnt || err !== e_err) begin
                n_err++;
                $display("FAIL %s release: got ov=%b ir=%b enc=%0d cnt=%0d err=%b want ov=0 ir=1 enc=%0d cnt=%0d err=%b",
                         name, out_valid, in_ready, enc_data, bit_cnt, err, e_enc, e_cnt, e_err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dec_data  = 16'h0000;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || enc_data !== 4'd0 ||
            bit_cnt !== 5'd0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got ir=%b ov=%b enc=%0d cnt=%0d err=%b want ir=1 ov=0 enc=0 cnt=0 err=0",
                     in_ready, out_valid, enc_data, bit_cnt, err);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_onehot();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) begin
            w = 16'h0001 << i;
            run_word(w, 4'(i), 5'd1, 1'b0, $sformatf("onehot%0d", i));
        end
    endtask

    task automatic test_illegal();
        run_word(16'h0000, 4'd0, 5'd0, 1'b1, "zero");
`ifdef ONEHOT_ENC_PRIORITY_EN
        run_word(16'h8421, 4'd15, 5'd4, 1'b0, "multi8421");
        run_word(16'hFFFF, 4'd15, 5'd16, 1'b0, "allones");
        run_word(16'h0006, 4'd2, 5'd2, 1'b0, "multi0006");
`else
        run_word(16'h8421, 4'd0, 5'd4, 1'b1, "multi8421");
        run_word(16'hFFFF, 4'd0, 5'd16, 1'b1, "allones");
        run_word(16'h0006, 4'd1, 5'd2, 1'b1, "multi0006");
`endif
    endtask

    task automatic test_backpressure();
        logic held_ok;
        out_ready = 1'b0;
        run_word(16'h0040, 4'd6, 5'd1, 1'b0, "bp0040");
        held_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            dec_data = 16'h0001 << k;
            in_valid = k[0];
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || enc_data !== 4'd6 ||
                bit_cnt !== 5'd1 || err !== 1'b0) held_ok = 1'b0;
        end
        n_vec++;
        if (held_ok !== 1'b1) begin
            n_err++;
            $display("FAIL bp_hold: got ov=%b enc=%0d cnt=%0d want ov=1 enc=6 cnt=1 held for 5 clocks",
                     out_valid, enc_data, bit_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || enc_data !== 4'd6) begin
            n_err++;
            $display("FAIL bp_release: got ov=%b ir=%b enc=%0d want ov=0 ir=1 enc=6",
                     out_valid, in_ready, enc_data);
        end
    endtask

    task automatic test_reset_midscan();
        out_ready = 1'b1;
        dec_data  = 16'h0100;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || enc_data !== 4'd0 ||
            bit_cnt !== 5'd0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL midscan_reset: got ir=%b ov=%b enc=%0d cnt=%0d err=%b want ir=1 ov=0 enc=0 cnt=0 err=0",
                     in_ready, out_valid, enc_data, bit_cnt, err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_word(16'h0002, 4'd1, 5'd1, 1'b0, "after_reset0002");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_onehot();
        test_illegal();
        test_backpressure();
        test_reset_midscan();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/onehot_encode_seq.md
ONEHOT_ENCODE_SEQ -- requirements
Module: onehot_encode_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning encoded index width; decoded word width is 2**WIDTH.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dec_data  input  2**WIDTH  decoded (one-hot) word to encode.
REQ-005 SHALL have port in_valid  input  1  dec_data valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a word.
REQ-007 SHALL have port enc_data  output  WIDTH  encoded index result.
REQ-008 SHALL have port bit_cnt  output  WIDTH+1  number of set bits in the accepted word.
REQ-009 SHALL have port err  output  1  accepted word was not a legal input.
REQ-010 SHALL have port out_valid  output  1  enc_data, bit_cnt, err valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, HOLD; reset state IDLE.
REQ-013 SHALL drive in_ready=1 only in IDLE, combinationally from state.
REQ-014 SHALL, in IDLE on in_valid&&in_ready at an edge, capture dec_data into an internal register, clear scan index, count and result, and enter SCAN.
REQ-015 SHALL ignore dec_data and in_valid in SCAN and HOLD; captured word is unaffected by later dec_data changes.
REQ-016 SHALL, in SCAN, examine one captured bit per clock, index 0 first, ascending to 2**WIDTH-1.
REQ-017 SHALL increment bit_cnt for each set bit examined; bit_cnt cannot overflow (max 2**WIDTH fits WIDTH+1 bits).
REQ-018 SHALL record into enc_data the index of the lowest set bit (default build, see REQ-026).
REQ-019 SHALL transition SCAN->HOLD on the edge that examines bit 2**WIDTH-1; out_valid=1 after that edge, i.e. exactly 2**WIDTH clocks after the accepting edge.
REQ-020 SHALL set err=1 in HOLD when bit_cnt!=1 (all-zero or multi-hot); enc_data=0 when bit_cnt=0.
REQ-021 SHALL hold enc_data, bit_cnt, err stable and out_valid=1 in HOLD until out_valid&&out_ready at an edge, then enter IDLE with out_valid=0.
REQ-022 SHALL keep last enc_data, bit_cnt, err values in IDLE until next accept clears them.
REQ-023 SHALL have minimum accept-to-accept spacing of 2**WIDTH+2 clocks (out_ready held high).

Reset
REQ-024 SHALL, on rst_n low at any time (including mid-SCAN or in HOLD), immediately force state IDLE, out_valid=0, enc_data=0, bit_cnt=0, err=0, scan index=0, captured word=0; in_ready=1 while rst_n low.
REQ-025 SHALL resume normal operation at first rising clk edge after rst_n deasserts; an aborted word produces no result.

Configuration
REQ-026 SHALL support macro ONEHOT_ENC_PRIORITY_EN: when defined, enc_data is the highest set index (later set bits overwrite) and err=1 only when bit_cnt=0; when undefined, behaviour is REQ-018/REQ-020 (lowest index, err on bit_cnt!=1). bit_cnt, timing and handshake identical in both builds.

Verification
REQ-027 SHALL cover, WIDTH=4, out_ready=1: all 16 one-hot words 0x0001..0x8000 -> enc_data=0..15, bit_cnt=1, err=0, out_valid exactly 16 clocks after each accept.
REQ-028 SHALL cover: dec_data=0x0000 -> enc_data=0, bit_cnt=0, err=1 (both builds).
REQ-029 SHALL cover: dec_data=0x8421 -> bit_cnt=4; default build enc_data=0, err=1; ONEHOT_ENC_PRIORITY_EN build enc_data=15, err=0.
REQ-030 SHALL cover: out_ready=0 for 5 clocks in HOLD after 0x0040 -> out_valid and enc_data=6 held 5 clocks, in_valid pulses and dec_data changes ignored; release -> IDLE next edge, in_ready=1.
REQ-031 SHALL cover: rst_n low at SCAN bit 7 of 0x0100 -> outputs 0 immediately, in_ready=1; following accept of 0x0002 -> enc_data=1, err=0, no stale result.
